// File: rtl/bus_target_pkg.sv
// Shared types and constants for the DMA bus target: state enums, timing widths,
// and the byte-lane helpers used for storage writes and read data.
package bus_target_pkg;

   typedef enum logic [1:0] {A_IDLE, A_GRANT, A_OWNED} arb_state_t;
   typedef enum logic [1:0] {C_IDLE, C_WAIT, C_TERM, C_END} cyc_state_t;

   localparam int GRANT_TIMEOUT = 16;
   localparam int GRANT_CNT_W   = $clog2(GRANT_TIMEOUT);
   localparam int WAIT_CNT_W    = 3;

   // A 16-bit port always carries word data on D31:16; a 32-bit port uses the lane matching A1.
   function automatic logic [31:0] lane_write(input logic [31:0] old_word,
                                              input logic [31:0] din,
                                              input logic        size1,
                                              input logic        a1,
                                              input logic        port32);
      logic [31:0] w_word;
      logic [15:0] w_half;
      w_word = old_word;
      w_half = (port32 && a1) ? din[15:0] : din[31:16];
      if (!size1)
         w_word = din;
      else if (a1)
         w_word[15:0] = w_half;
      else
         w_word[31:16] = w_half;
      return w_word;
   endfunction

   function automatic logic [31:0] lane_read(input logic [31:0] word,
                                             input logic        size1,
                                             input logic        a1,
                                             input logic        port32);
      logic [31:0] w_rd;
      w_rd = '0;
      if (!size1)
         w_rd = word;
      else if (!a1)
         w_rd[31:16] = word[31:16];
      else if (port32)
         w_rd[15:0] = word[15:0];
      else
         w_rd[31:16] = word[15:0];
      return w_rd;
   endfunction

endpackage

// File: rtl/bus_grant_arb.sv
// Bus grant arbiter for the DMA master, with grant withdrawal on BGACK timeout.
//   state   | meaning
//   A_IDLE  | no request pending, grant released
//   A_GRANT | grant driven, waiting for BGACK (timeout down-counter running)
//   A_OWNED | master owns the bus until BGACK drops
module bus_grant_arb
   import bus_target_pkg::*;
(
   input  logic CLK,
   input  logic aRESET_,
   input  logic BREQ,
   input  logic BGACK,
   output logic aBGRANT_
);

   arb_state_t             r_state;
   logic [GRANT_CNT_W-1:0] r_tmo;
   logic                   r_bgrant_n;

   always_ff @(posedge CLK or negedge aRESET_) begin
      if (!aRESET_) begin
         r_state    <= A_IDLE;
         r_tmo      <= '0;
         r_bgrant_n <= 1'b1;
      end else begin
         case (r_state)
            A_IDLE: begin
               if (BREQ) begin
                  r_state    <= A_GRANT;
                  r_tmo      <= GRANT_CNT_W'(GRANT_TIMEOUT - 1);
                  r_bgrant_n <= 1'b0;
               end
            end
            A_GRANT: begin
               if (BGACK) begin
                  r_state    <= A_OWNED;
                  r_tmo      <= '0;
                  r_bgrant_n <= 1'b1;
               end else if (!BREQ || r_tmo == '0) begin
                  r_state    <= A_IDLE;
                  r_tmo      <= '0;
                  r_bgrant_n <= 1'b1;
               end else begin
                  r_tmo <= r_tmo - GRANT_CNT_W'(1);
               end
            end
            A_OWNED: begin
               if (!BGACK)
                  r_state <= A_IDLE;
            end
            default: begin
               r_state    <= A_IDLE;
               r_bgrant_n <= 1'b1;
            end
         endcase
      end
   end

   assign aBGRANT_ = r_bgrant_n;

endmodule

// File: rtl/bus_target_sm.sv
// DMA bus target: grant arbiter plus a wait-stated cycle FSM over 4 x 32-bit storage.
//   state  | meaning
//   C_IDLE | waiting for PAS while the master holds BGACK
//   C_WAIT | wait-state down-counter runs while PDS is high; PAS low aborts
//   C_TERM | termination asserted, write committed / read data presented
//   C_END  | termination held until PAS drops
module bus_target_sm
   import bus_target_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   parameter int SYNC_TERM   = 0,
   parameter int PORT32      = 1
) (
   input  logic        CLK,
   input  logic        aRESET_,
   input  logic        BREQ,
   input  logic        BGACK,
   output logic        aBGRANT_,
   input  logic        PAS,
   input  logic        PDS,
   input  logic        DMADIR,
   input  logic        SIZE1,
   input  logic        A1,
   input  logic [1:0]  ADDR,
   input  logic [31:0] DATA_IN,
   output logic [31:0] DATA_OUT,
   output logic        DSACK0_,
   output logic        DSACK1_,
   output logic        STERM_
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
   localparam logic                  IS_SYNC   = (SYNC_TERM != 0);
   localparam logic                  IS_P32    = (PORT32 != 0);

   cyc_state_t            r_state;
   logic [WAIT_CNT_W-1:0] r_wcnt;
   logic                  r_dir;
   logic                  r_size1;
   logic                  r_a1;
   logic [1:0]            r_addr;
   logic                  r_dsack0_n;
   logic                  r_dsack1_n;
   logic                  r_sterm_n;
   logic [31:0]           r_dout;
   logic [31:0]           r_mem [4];

   bus_grant_arb u_arb (
      .CLK      (CLK),
      .aRESET_  (aRESET_),
      .BREQ     (BREQ),
      .BGACK    (BGACK),
      .aBGRANT_ (aBGRANT_)
   );

   always_ff @(posedge CLK or negedge aRESET_) begin
      if (!aRESET_) begin
         r_state    <= C_IDLE;
         r_wcnt     <= '0;
         r_dir      <= 1'b0;
         r_size1    <= 1'b0;
         r_a1       <= 1'b0;
         r_addr     <= '0;
         r_dsack0_n <= 1'b1;
         r_dsack1_n <= 1'b1;
         r_sterm_n  <= 1'b1;
         r_dout     <= '0;
         for (int i = 0; i < 4; i++)
            r_mem[i] <= '0;
      end else begin
         case (r_state)
            C_IDLE: begin
               // Address-phase attributes are captured once; BGACK is only required to start.
               if (PAS && BGACK) begin
                  r_state <= C_WAIT;
                  r_wcnt  <= WAIT_LOAD;
                  r_dir   <= DMADIR;
                  r_size1 <= SIZE1;
                  r_a1    <= A1;
                  r_addr  <= ADDR;
               end
            end
            C_WAIT: begin
               if (!PAS) begin
                  r_state <= C_IDLE;
               end else if (PDS) begin
                  if (r_wcnt == '0) begin
                     r_state <= C_TERM;
                     if (IS_SYNC) begin
                        r_sterm_n <= 1'b0;
                     end else begin
                        r_dsack1_n <= 1'b0;
                        r_dsack0_n <= !IS_P32;
                     end
                     if (r_dir)
                        r_mem[r_addr] <= lane_write(r_mem[r_addr], DATA_IN, r_size1, r_a1, IS_P32);
                     else
                        r_dout <= lane_read(r_mem[r_addr], r_size1, r_a1, IS_P32);
                  end else begin
                     r_wcnt <= r_wcnt - WAIT_CNT_W'(1);
                  end
               end
            end
            C_TERM: begin
               r_state   <= C_END;
               r_sterm_n <= 1'b1;
            end
            C_END: begin
               if (!PAS) begin
                  r_state    <= C_IDLE;
                  r_dsack0_n <= 1'b1;
                  r_dsack1_n <= 1'b1;
                  r_sterm_n  <= 1'b1;
                  r_dout     <= '0;
               end
            end
            default: r_state <= C_IDLE;
         endcase
      end
   end

   assign DSACK0_  = r_dsack0_n;
   assign DSACK1_  = r_dsack1_n;
   assign STERM_   = r_sterm_n;
   assign DATA_OUT = r_dout;

endmodule

// File: tb/tb_bus_target_sm.sv
// Scoreboard bench: three bus_target_sm variants (default, 16-bit port, sync/zero-wait)
// with directed cycles; a monitor checks grant edges and termination events against queues.
module tb_bus_target_sm;

   logic        clk;
   logic        rst_n;
   int          cyc;
   logic        breq   [3];
   logic        bgack  [3];
   logic        pas    [3];
   logic        pds    [3];
   logic        dmadir [3];
   logic        size1  [3];
   logic        a1     [3];
   logic [1:0]  addr   [3];
   logic [31:0] din    [3];
   logic [31:0] dout   [3];
   logic        gnt_n  [3];
   logic        d0_n   [3];
   logic        d1_n   [3];
   logic        st_n   [3];

   typedef struct {
      int          dut;
      int          cyc_on;
      int          cyc_off;
      logic        d0;
      logic        d1;
      logic        st;
      logic [31:0] dout_on;
      logic [31:0] dout_off;
   } term_t;

   typedef struct {
      int   cyc;
      logic val;
   } gnt_t;

   term_t tq[$];
   gnt_t  gq[$];
   term_t pend [3];
   int    n_term_exp  [3];
   int    n_term_seen [3];
   int    n_tests;
   int    n_fail;
   bit    mon_en;

   bus_target_sm #(.WAIT_STATES(2), .SYNC_TERM(0), .PORT32(1)) u_def (
      .CLK(clk), .aRESET_(rst_n), .BREQ(breq[0]), .BGACK(bgack[0]), .aBGRANT_(gnt_n[0]),
      .PAS(pas[0]), .PDS(pds[0]), .DMADIR(dmadir[0]), .SIZE1(size1[0]), .A1(a1[0]),
      .ADDR(addr[0]), .DATA_IN(din[0]), .DATA_OUT(dout[0]),
      .DSACK0_(d0_n[0]), .DSACK1_(d1_n[0]), .STERM_(st_n[0]));

   bus_target_sm #(.WAIT_STATES(2), .SYNC_TERM(0), .PORT32(0)) u_p16 (
      .CLK(clk), .aRESET_(rst_n), .BREQ(breq[1]), .BGACK(bgack[1]), .aBGRANT_(gnt_n[1]),
      .PAS(pas[1]), .PDS(pds[1]), .DMADIR(dmadir[1]), .SIZE1(size1[1]), .A1(a1[1]),
      .ADDR(addr[1]), .DATA_IN(din[1]), .DATA_OUT(dout[1]),
      .DSACK0_(d0_n[1]), .DSACK1_(d1_n[1]), .STERM_(st_n[1]));

   bus_target_sm #(.WAIT_STATES(0), .SYNC_TERM(1), .PORT32(1)) u_syn (
      .CLK(clk), .aRESET_(rst_n), .BREQ(breq[2]), .BGACK(bgack[2]), .aBGRANT_(gnt_n[2]),
      .PAS(pas[2]), .PDS(pds[2]), .DMADIR(dmadir[2]), .SIZE1(size1[2]), .A1(a1[2]),
      .ADDR(addr[2]), .DATA_IN(din[2]), .DATA_OUT(dout[2]),
      .DSACK0_(d0_n[2]), .DSACK1_(d1_n[2]), .STERM_(st_n[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every grant edge and every termination assert/release must match a queued expectation.
   initial begin
      logic prev_act [3];
      logic prev_gnt;
      logic act;
      term_t t;
      gnt_t g;
      prev_gnt = 1'b1;
      for (int d = 0; d < 3; d++) prev_act[d] = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            for (int d = 0; d < 3; d++) prev_act[d] = !(d0_n[d] && d1_n[d] && st_n[d]);
            prev_gnt = gnt_n[0];
         end else begin
            for (int d = 0; d < 3; d++) begin
               act = !(d0_n[d] && d1_n[d] && st_n[d]);
               if (act && !prev_act[d]) begin
                  n_term_seen[d]++;
                  if (tq.size() == 0) begin
                     chk("unexpected_term", {29'd0, d0_n[d], d1_n[d], st_n[d]}, 32'h7);
                  end else begin
                     t = tq.pop_front();
                     pend[d] = t;
                     chk("term_dut", d, t.dut);
                     chk("term_on_cyc", cyc, t.cyc_on);
                     chk("dsack0_n", {31'd0, d0_n[d]}, {31'd0, t.d0});
                     chk("dsack1_n", {31'd0, d1_n[d]}, {31'd0, t.d1});
                     chk("sterm_n", {31'd0, st_n[d]}, {31'd0, t.st});
                     chk("dout_at_term", dout[d], t.dout_on);
                  end
               end else if (!act && prev_act[d]) begin
                  chk("term_off_cyc", cyc, pend[d].cyc_off);
                  chk("dout_at_release", dout[d], pend[d].dout_off);
               end
               prev_act[d] = act;
            end
            if (gnt_n[0] !== prev_gnt) begin
               if (gq.size() == 0) begin
                  chk("unexpected_grant_edge", {31'd0, gnt_n[0]}, {31'd0, prev_gnt});
               end else begin
                  g = gq.pop_front();
                  chk("grant_cyc", cyc, g.cyc);
                  chk("grant_val", {31'd0, gnt_n[0]}, {31'd0, g.val});
               end
               prev_gnt = gnt_n[0];
            end
         end
      end
   end

   task automatic push_gnt(input int c, input logic v);
      gnt_t g;
      g.cyc = c;
      g.val = v;
      gq.push_back(g);
   endtask

   // One bus cycle on DUT d; PDS is driven one clock after PAS. Abort drops PAS after one wait clock.
   task automatic bus_cycle(input int d, input logic dir, input logic sz, input logic a1v,
                            input logic [1:0] ad, input logic [31:0] wd, input logic [31:0] rd_exp,
                            input bit abort, input bit drop_bgack);
      int    w;
      int    p;
      term_t t;
      w = (d == 2) ? 0 : 2;
      dmadir[d] = dir;
      size1[d]  = sz;
      a1[d]     = a1v;
      addr[d]   = ad;
      din[d]    = wd;
      pas[d]    = 1'b1;
      step();
      pds[d] = 1'b1;
      p = cyc;
      if (drop_bgack) bgack[d] = 1'b0;
      if (abort) begin
         step();
         pas[d] = 1'b0;
         pds[d] = 1'b0;
         step();
         step();
         return;
      end
      t.dut     = d;
      t.cyc_on  = p + 1 + w;
      t.d0      = (d == 0) ? 1'b0 : 1'b1;
      t.d1      = (d == 2) ? 1'b1 : 1'b0;
      t.st      = (d == 2) ? 1'b0 : 1'b1;
      t.dout_on = dir ? 32'h0 : rd_exp;
      if (d == 2) begin
         t.cyc_off  = p + 2;
         t.dout_off = t.dout_on;
      end else begin
         t.cyc_off  = p + w + 4;
         t.dout_off = 32'h0;
      end
      tq.push_back(t);
      n_term_exp[d]++;
      while (cyc < p + w + 3) step();
      pas[d] = 1'b0;
      pds[d] = 1'b0;
      step();
      step();
   endtask

   initial begin
      int n;
      n_tests = 0;
      n_fail  = 0;
      mon_en  = 1'b0;
      for (int d = 0; d < 3; d++) begin
         breq[d] = 0; bgack[d] = 0; pas[d] = 0; pds[d] = 0; dmadir[d] = 0;
         size1[d] = 0; a1[d] = 0; addr[d] = '0; din[d] = '0;
         n_term_exp[d] = 0; n_term_seen[d] = 0;
      end
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      step();
      step();
      for (int d = 0; d < 3; d++) begin
         chk("rst_bgrant_n", {31'd0, gnt_n[d]}, 32'd1);
         chk("rst_dsack0_n", {31'd0, d0_n[d]}, 32'd1);
         chk("rst_dsack1_n", {31'd0, d1_n[d]}, 32'd1);
         chk("rst_sterm_n", {31'd0, st_n[d]}, 32'd1);
         chk("rst_data_out", dout[d], 32'd0);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mon_en = 1'b1;
      step();

      // Grant handshake on the default DUT
      breq[0] = 1'b1;
      push_gnt(cyc + 1, 1'b0);
      step();
      step();
      bgack[0] = 1'b1;
      push_gnt(cyc + 1, 1'b1);
      step();
      breq[0] = 1'b0;
      bgack[1] = 1'b1;
      bgack[2] = 1'b1;
      step();

      // Default DUT: longword, word lanes, abort, BGACK drop mid-cycle
      bus_cycle(0, 1, 0, 0, 2'd2, 32'hDEADBEEF, 32'h0, 0, 0);
      bus_cycle(0, 0, 0, 0, 2'd2, 32'hA5A5A5A5, 32'hDEADBEEF, 0, 0);
      bus_cycle(0, 1, 1, 1, 2'd1, 32'h00005A5A, 32'h0, 0, 0);
      bus_cycle(0, 1, 1, 0, 2'd1, 32'hC3C30000, 32'h0, 0, 0);
      bus_cycle(0, 0, 0, 0, 2'd1, 32'h11111111, 32'hC3C35A5A, 0, 0);
      bus_cycle(0, 0, 1, 1, 2'd1, 32'h22222222, 32'h00005A5A, 0, 0);
      bus_cycle(0, 0, 1, 0, 2'd1, 32'h33333333, 32'hC3C30000, 0, 0);
      bus_cycle(0, 1, 0, 0, 2'd3, 32'hFFFFFFFF, 32'h0, 1, 0);
      bus_cycle(0, 0, 0, 0, 2'd3, 32'h44444444, 32'h00000000, 0, 0);
      bus_cycle(0, 0, 0, 0, 2'd2, 32'h55555555, 32'hDEADBEEF, 0, 1);

      // Grant timeout: BGACK never arrives
      breq[0] = 1'b1;
      n = cyc;
      push_gnt(n + 1, 1'b0);
      push_gnt(n + 17, 1'b1);
      while (cyc < n + 17) step();
      breq[0] = 1'b0;
      step();
      step();

      // 16-bit port DUT
      bus_cycle(1, 1, 1, 1, 2'd0, 32'h12340000, 32'h0, 0, 0);
      bus_cycle(1, 0, 0, 0, 2'd0, 32'h66666666, 32'h00001234, 0, 0);
      bus_cycle(1, 1, 1, 0, 2'd0, 32'hABCD0000, 32'h0, 0, 0);
      bus_cycle(1, 0, 1, 1, 2'd0, 32'h77777777, 32'h12340000, 0, 0);
      bus_cycle(1, 0, 0, 0, 2'd0, 32'h88888888, 32'hABCD1234, 0, 0);

      // Synchronous termination, zero wait states
      bus_cycle(2, 1, 0, 0, 2'd1, 32'h0F0F0F0F, 32'h0, 0, 0);
      bus_cycle(2, 0, 0, 0, 2'd1, 32'h99999999, 32'h0F0F0F0F, 0, 0);

      step();
      step();
      for (int d = 0; d < 3; d++)
         chk("term_event_count", n_term_seen[d], n_term_exp[d]);
      chk("term_queue_left", tq.size(), 0);
      chk("grant_queue_left", gq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_target_sm.md
BUS_TARGET_SM -- requirements
Module: bus_target_sm

Interface
REQ-001 Parameter WAIT_STATES, default 2, SHALL set the clocks between PDS assertion and termination (range 0..7).
REQ-002 Parameter SYNC_TERM, default 0, SHALL select termination: 1 uses STERM_, 0 uses DSACK.
REQ-003 Parameter PORT32, default 1, SHALL select port width: 1 means a 32-bit port (DSACK0_ and DSACK1_), 0 means a 16-bit port (DSACK1_ only).
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 aRESET_  in  1  asynchronous, active-low reset.
REQ-006 BREQ  in  1  bus request from the DMA master, active high.
REQ-007 BGACK  in  1  bus grant acknowledge from the master, active high.
REQ-008 aBGRANT_  out  1  bus grant to the master, active low.
REQ-009 PAS  in  1  address strobe from the master, active high.
REQ-010 PDS  in  1  data strobe from the master, active high.
REQ-011 DMADIR  in  1  direction: 1 means the master writes to the target, 0 means the master reads.
REQ-012 SIZE1  in  1  transfer size: 1 means word, 0 means longword.
REQ-013 A1  in  1  word select within a longword.
REQ-014 ADDR  in  2  longword index into 4 x 32-bit storage.
REQ-015 DATA_IN  in  32  write data from the master.
REQ-016 DATA_OUT  out  32  read data to the master.
REQ-017 DSACK0_, DSACK1_  out  1 each  asynchronous cycle termination, active low.
REQ-018 STERM_  out  1  synchronous termination, active low.

Function
REQ-019 The arbiter SHALL implement states A_IDLE, A_GRANT and A_OWNED.
REQ-020 In A_IDLE with BREQ=1, the arbiter SHALL go to A_GRANT and drive aBGRANT_=0 from the next clock.
REQ-021 In A_GRANT with BGACK=1, the arbiter SHALL go to A_OWNED and drive aBGRANT_=1 one clock after BGACK is sampled.
REQ-022 In A_GRANT with BREQ=0 and BGACK=0, the arbiter SHALL return to A_IDLE and drive aBGRANT_=1.
REQ-023 The arbiter SHALL withdraw the grant and return to A_IDLE after GRANT_TIMEOUT=16 clocks in A_GRANT without BGACK.
REQ-024 In A_OWNED, BGACK=0 SHALL return the arbiter to A_IDLE; a simultaneous BREQ=1 is serviced from A_IDLE on the next clock.
REQ-025 The cycle FSM SHALL implement states C_IDLE, C_WAIT, C_TERM and C_END.
REQ-026 In C_IDLE, PAS=1 with BGACK=1 SHALL move the FSM to C_WAIT and load the wait counter with WAIT_STATES; PAS with BGACK=0 SHALL be ignored.
REQ-027 In C_WAIT, the counter SHALL decrement each clock while PDS=1; with counter=0 and PDS=1, the FSM SHALL move to C_TERM.
REQ-028 In C_TERM, the block SHALL assert termination: for SYNC_TERM=1, STERM_=0 for exactly one clock; for SYNC_TERM=0, DSACK1_=0 (plus DSACK0_=0 when PORT32=1), held until PAS=0.
REQ-029 C_TERM SHALL go to C_END after one clock; C_END SHALL hold until PAS=0, then release all termination and return to C_IDLE.
REQ-030 Minimum latency from PDS sampled high to termination asserted SHALL be WAIT_STATES+1 clocks.
REQ-031 A write (DMADIR=1) SHALL update storage[ADDR] on the C_TERM entry clock.
REQ-032 A longword write SHALL write all 32 bits.
REQ-033 A word write on a 32-bit port SHALL write bits 31:16 when A1=0 and bits 15:0 when A1=1, taken from the same DATA_IN lanes.
REQ-034 A word write on a 16-bit port SHALL take DATA_IN[31:16] into the half selected by A1.
REQ-035 A read (DMADIR=0) SHALL drive DATA_OUT from C_TERM until C_END exits, using the same lane mapping as writes.
REQ-036 DATA_OUT SHALL be 0 outside a read cycle.
REQ-037 PAS falling in C_WAIT (abort) SHALL return the FSM to C_IDLE with no storage write and no termination.
REQ-038 BGACK falling during a cycle SHALL NOT abort the cycle.

Reset
REQ-039 aRESET_=0 SHALL asynchronously force A_IDLE and C_IDLE, aBGRANT_=1, DSACK0_=1, DSACK1_=1, STERM_=1, DATA_OUT=0, all storage to 0, and the counters to 0.
REQ-040 Reset asserted mid-cycle SHALL drop termination immediately, and no partial write SHALL occur.

Structure
REQ-041 Package bus_target_pkg SHALL hold the arbiter and cycle state enums, GRANT_TIMEOUT=16 and the 3-bit wait-counter width.
REQ-042 The arbiter SHALL be a sub-module, bus_grant_arb, containing A-states, the timeout counter and aBGRANT_.

Verification
REQ-043 Reset release, then BREQ=1 -> aBGRANT_=0 next clock; BGACK=1 -> aBGRANT_=1 one clock later.
REQ-044 BREQ=1 with BGACK held 0 -> aBGRANT_ returns to 1 after 16 clocks.
REQ-045 Defaults: write longword 0xDEADBEEF to ADDR=2, then read it back -> DSACK0_=DSACK1_=0 exactly 3 clocks after PDS; read gives DATA_OUT=0xDEADBEEF.
REQ-046 PORT32=0, word write 0x1234 on D31:16 with A1=1 to ADDR=0 -> DSACK1_=0, DSACK0_=1; readback longword gives 0x00001234.
REQ-047 SYNC_TERM=1, WAIT_STATES=0 -> STERM_=0 for exactly one clock, 1 clock after PDS.
REQ-048 PAS dropped after 1 wait clock on a write of 0xFFFFFFFF -> no termination; storage unchanged (0).
